// File: rtl/race_lane_renderer.sv
// Race-game lane renderer: draws background, then a car sprite, then erases/redraws it on lane changes.
// Optional dashed lane dividers in the background when RACE_LANE_MARKS_EN is defined.
module race_lane_renderer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int ROAD_X0  = 40,
    parameter int ROAD_W   = 80,
    parameter int LANES    = 3,
    parameter int CAR_W    = 8,
    parameter int CAR_H    = 12,
    parameter int CAR_Y    = 100
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         straight,
    input  logic                         left,
    input  logic                         right,
    input  logic                         oneframe,
    output logic [$clog2(SCREEN_W)-1:0]  x,
    output logic [$clog2(SCREEN_H)-1:0]  y,
    output logic [2:0]                   colour,
    output logic                         plot,
    output logic                         ready,
    output logic [$clog2(LANES)-1:0]     lane,
    output logic [15:0]                  distance
);
    localparam int XW     = $clog2(SCREEN_W);
    localparam int YW     = $clog2(SCREEN_H);
    localparam int LW     = $clog2(LANES);
    localparam int LANE_W = ROAD_W / LANES;

    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] CAR   = 3'b100;
`ifdef RACE_LANE_MARKS_EN
    localparam logic [2:0] MARK  = 3'b111;
`endif

    typedef enum logic [2:0] {S_IDLE, S_BG, S_CAR, S_WAIT, S_ERASE, S_UPDATE} state_t;
    state_t state;
    logic   move_left;

    function automatic logic [XW-1:0] car_x_of(input logic [LW-1:0] l);
        int signed v;
        v = ROAD_X0 + int'(l) * LANE_W + (LANE_W - CAR_W) / 2;
        return XW'(v);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [XW-1:0] cx, bg_nx, car_nx, pix_x;
    logic [YW-1:0] bg_ny, car_ny;
    logic          bg_x_end, bg_last, car_x_end, car_last;
    logic [2:0]    bg_col;
`ifdef RACE_LANE_MARKS_EN
    logic [YW-1:0] pix_y;
`endif

    // Next raster position for the background sweep and the car rectangle.
    always_comb begin
        cx        = car_x_of(lane);
        bg_x_end  = (int'(x) == SCREEN_W - 1);
        bg_last   = bg_x_end && (int'(y) == SCREEN_H - 1);
        bg_nx     = bg_x_end ? '0 : x + XW'(1);
        bg_ny     = bg_x_end ? y + YW'(1) : y;
        car_x_end = (x == cx + XW'(CAR_W - 1));
        car_last  = car_x_end && (int'(y) == CAR_Y + CAR_H - 1);
        car_nx    = car_x_end ? cx : x + XW'(1);
        car_ny    = car_x_end ? y + YW'(1) : y;
        pix_x     = (state == S_BG) ? bg_nx : '0;
        bg_col    = (int'(pix_x) < ROAD_X0 || int'(pix_x) >= ROAD_X0 + ROAD_W) ? GREEN : BLACK;
`ifdef RACE_LANE_MARKS_EN
        pix_y     = (state == S_BG) ? bg_ny : '0;
        if (!pix_y[2]) begin
            for (int k = 1; k < LANES; k++) begin
                if (int'(pix_x) == ROAD_X0 + k * LANE_W) bg_col = MARK;
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            ready     <= 1'b0;
            distance  <= '0;
            lane      <= LW'(LANES / 2);
            move_left <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_BG;
                        distance <= '0;
                        x        <= '0;
                        y        <= '0;
                        colour   <= bg_col;
                        plot     <= 1'b1;
                    end
                end
                S_BG: begin
                    if (bg_last) begin
                        state  <= S_CAR;
                        x      <= cx;
                        y      <= YW'(CAR_Y);
                        colour <= CAR;
                    end else begin
                        x      <= bg_nx;
                        y      <= bg_ny;
                        colour <= bg_col;
                    end
                end
                S_CAR, S_ERASE: begin
                    if (car_last) begin
                        state <= (state == S_CAR) ? S_WAIT : S_UPDATE;
                        plot  <= 1'b0;
                        ready <= (state == S_CAR);
                    end else begin
                        x <= car_nx;
                        y <= car_ny;
                    end
                end
                S_WAIT: begin
                    if (oneframe) begin
                        if (straight) begin
                            distance <= sat_inc16(distance);
                        end else if (left || right) begin
                            // Left outranks right even when it is blocked at the edge.
                            if (left ? (lane != '0) : (int'(lane) < LANES - 1)) begin
                                state     <= S_ERASE;
                                move_left <= left;
                                ready     <= 1'b0;
                                plot      <= 1'b1;
                                x         <= cx;
                                y         <= YW'(CAR_Y);
                                colour    <= BLACK;
                            end
                        end
                    end
                end
                S_UPDATE: begin
                    state  <= S_CAR;
                    lane   <= move_left ? lane - LW'(1) : lane + LW'(1);
                    x      <= move_left ? cx - XW'(LANE_W) : cx + XW'(LANE_W);
                    y      <= YW'(CAR_Y);
                    colour <= CAR;
                    plot   <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
